// File: rtl/urv_defs_pkg.sv
// Shared definitions for the uRV front end: NOP encoding, fetch FSM states
// and small address helpers.
package urv_defs;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/urv_fetch_skid.sv
// One-entry skid buffer holding a {pc, instruction} pair that arrived while
// decode was stalled.
module urv_fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        pop,
  input  logic        clear,
  input  logic [63:0] data_in,
  output logic        valid,
  output logic [63:0] data_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      // A redirect always wins: the held entry belongs to the old path.
      if (clear)
        valid <= 1'b0;
      else if (load)
        valid <= 1'b1;
      else if (pop)
        valid <= 1'b0;
      if (load)
        data_out <= data_in;
    end
  end

endmodule

// File: rtl/urv_fetch.sv
// uRV instruction fetch: issues one-cycle-latency memory reads, absorbs decode
// stalls with a one-entry skid buffer and handles redirects from execute.
module urv_fetch
  import urv_defs::*;
#(
  parameter logic [31:0] g_boot_address = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  output logic [31:0]  im_addr_o,
  output logic         im_rd_o,
  input  logic [31:0]  im_data_i,
  input  logic         im_valid_i,
  input  logic         f_stall_i,
  input  logic         x_bra_i,
  input  logic [31:0]  x_bra_target_i,
  output logic [31:0]  f_ir_o,
  output logic [31:0]  f_pc_o,
  output logic         f_valid_o,
  output fetch_state_e dbg_state_o
);

  // Handshake: im_rd_o qualifies im_addr_o and the memory answers with
  // im_valid_i exactly one cycle later. Towards decode, f_valid_o marks f_*
  // as an instruction; f_stall_i high means decode did not take it, so f_*
  // hold. An instruction is consumed on a cycle with f_valid_o && !f_stall_i.

  fetch_state_e state, state_nxt;
  logic [31:0]  rq_pc, pend_pc;
  logic         pend;
  logic         rsp_ok, skid_load, skid_pop, skid_valid;
  logic [63:0]  skid_data;

  assign im_addr_o   = rq_pc;
  // Never issue while the skid holds data, nor when a stalled decode would
  // meet a second response it cannot store.
  assign im_rd_o     = (state != ST_BOOT) && !x_bra_i && !skid_valid
                       && !(f_stall_i && pend);
  assign rsp_ok      = im_valid_i && (state == ST_RUN) && !x_bra_i;
  assign skid_load   = rsp_ok && f_stall_i;
  assign skid_pop    = skid_valid && !f_stall_i && !x_bra_i;
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state <= ST_BOOT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  state_nxt = ST_RUN;
      ST_RUN:   if (x_bra_i && pend) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rq_pc   <= g_boot_address;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      pend <= im_rd_o;
      if (im_rd_o)
        pend_pc <= rq_pc;
      if (x_bra_i)
        rq_pc <= word_align(x_bra_target_i);
      else if (im_rd_o)
        rq_pc <= rq_pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      f_valid_o <= 1'b0;
      f_pc_o    <= '0;
      f_ir_o    <= NOP_INSN;
    end else if (x_bra_i) begin
      f_valid_o <= 1'b0;
    end else if (!f_stall_i) begin
      // Skid and a fresh response never coincide: a full skid blocks requests.
      if (skid_valid) begin
        {f_pc_o, f_ir_o} <= skid_data;
        f_valid_o        <= 1'b1;
      end else if (rsp_ok) begin
        f_pc_o    <= pend_pc;
        f_ir_o    <= im_data_i;
        f_valid_o <= 1'b1;
      end else begin
        f_valid_o <= 1'b0;
      end
    end
  end

  urv_fetch_skid u_skid (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .load     (skid_load),
    .pop      (skid_pop),
    .clear    (x_bra_i),
    .data_in  ({pend_pc, im_data_i}),
    .valid    (skid_valid),
    .data_out (skid_data)
  );

endmodule

// File: tb/tb_urv_fetch.sv
// Bench for urv_fetch: directed timing scenarios plus randomized stall and
// redirect traffic scored against a program-order fetch model.
module tb_urv_fetch;
  import urv_defs::*;

  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [31:0]  im_addr_o;
  logic         im_rd_o;
  logic [31:0]  im_data_i;
  logic         im_valid_i;
  logic         f_stall_i;
  logic         x_bra_i;
  logic [31:0]  x_bra_target_i;
  logic [31:0]  f_ir_o;
  logic [31:0]  f_pc_o;
  logic         f_valid_o;
  fetch_state_e dbg_state_o;

  urv_fetch #(.g_boot_address(BOOT)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .im_addr_o      (im_addr_o),
    .im_rd_o        (im_rd_o),
    .im_data_i      (im_data_i),
    .im_valid_i     (im_valid_i),
    .f_stall_i      (f_stall_i),
    .x_bra_i        (x_bra_i),
    .x_bra_target_i (x_bra_target_i),
    .f_ir_o         (f_ir_o),
    .f_pc_o         (f_pc_o),
    .f_valid_o      (f_valid_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard state
  int           checks = 0;
  int           errors = 0;
  logic [63:0]  exp_q[$];
  logic [31:0]  next_pc, req_exp, last_cons_pc;
  logic         prev_bra, saw_wrap;
  int           gap, stall_rd, stall_rsp, flush_cnt;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic         obs_rd, obs_valid;
  logic [31:0]  obs_addr, obs_pc;
  fetch_state_e obs_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_pc  = BOOT;
    req_exp  = BOOT;
    prev_bra = 1'b0;
    gap      = 0;
  endtask

  // Sample everything at the falling edge and score it.
  task automatic observe();
    logic [63:0] e;
    if (im_rd_o) begin
      check("rd_addr", im_addr_o, req_exp);
      req_exp = req_exp + 32'd4;
    end
    if (x_bra_i) check("rd_on_bra", {31'b0, im_rd_o}, 32'd0);
    if (prev_bra) check("valid_after_bra", {31'b0, f_valid_o}, 32'd0);
    if (f_valid_o && !f_stall_i) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back({next_pc, next_pc ^ KEY});
        next_pc = next_pc + 32'd4;
      end
      e = exp_q.pop_front();
      check("f_pc", f_pc_o, e[63:32]);
      check("f_ir", f_ir_o, e[31:0]);
      if (f_pc_o == 32'h0 && last_cons_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      last_cons_pc = f_pc_o;
    end
    if (f_stall_i) begin
      stall_rd  += int'(im_rd_o);
      stall_rsp += int'(im_valid_i);
    end
    if (dbg_state_o == ST_FLUSH) flush_cnt++;
    if (f_valid_o || x_bra_i) gap = 0;
    else if (!f_stall_i) gap++;
    check("live", {31'b0, gap <= 8}, 32'd1);
    if (x_bra_i) begin
      exp_q.delete();
      next_pc = {x_bra_target_i[31:2], 2'b00};
      req_exp = next_pc;
    end
    prev_bra  = x_bra_i;
    obs_rd    = im_rd_o;
    obs_addr  = im_addr_o;
    obs_valid = f_valid_o;
    obs_pc    = f_pc_o;
    obs_state = dbg_state_o;
  endtask

  // driver: one clock cycle, entered and left at posedge + 1
  task automatic cycle(input logic stall, input logic bra, input logic [31:0] tgt);
    f_stall_i      = stall;
    x_bra_i        = bra;
    x_bra_target_i = tgt;
    im_valid_i     = mem_rd;
    im_data_i      = mem_addr ^ KEY;
    @(negedge clk_i);
    observe();
    mem_rd   = im_rd_o;
    mem_addr = im_addr_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd"},    {31'b0, im_rd_o},   32'd0);
    check({tag, "_valid"}, {31'b0, f_valid_o}, 32'd0);
    check({tag, "_pc"},    f_pc_o,             32'd0);
    check({tag, "_ir"},    f_ir_o,             32'h0000_0013);
    check({tag, "_state"}, {30'b0, dbg_state_o}, {30'b0, ST_BOOT});
  endtask

  task automatic pulse_reset();
    f_stall_i  = 1'b0;
    x_bra_i    = 1'b0;
    im_valid_i = mem_rd;
    im_data_i  = mem_addr ^ KEY;
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_values("async_rst");
    mem_rd = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic boot_sequence(input string tag);
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (i == 1) check({tag, "_c1_rd"}, {31'b0, obs_rd}, 32'd0);
      if (i == 2) begin
        check({tag, "_c2_rd"},   {31'b0, obs_rd}, 32'd1);
        check({tag, "_c2_addr"}, obs_addr, BOOT);
      end
      if (i == 3) check({tag, "_c3_valid"}, {31'b0, obs_valid}, 32'd0);
      if (i >= 4) begin
        check({tag, "_valid"}, {31'b0, obs_valid}, 32'd1);
        check({tag, "_pc"}, obs_pc, BOOT + 32'(4 * (i - 4)));
      end
    end
  endtask

  initial begin
    logic        st, br;
    logic [31:0] tgt;
    rst_n_i        = 1'b0;
    f_stall_i      = 1'b0;
    x_bra_i        = 1'b0;
    x_bra_target_i = 32'h0;
    im_valid_i     = 1'b0;
    im_data_i      = 32'h0;
    mem_rd         = 1'b0;
    mem_addr       = 32'h0;
    last_cons_pc   = 32'h0;
    saw_wrap       = 1'b0;
    stall_rd       = 0;
    stall_rsp      = 0;
    flush_cnt      = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_values("reset");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // boot timing and first three instructions
    boot_sequence("boot");

    // three-cycle stall mid-stream
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    stall_rd  = 0;
    stall_rsp = 0;
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    check("stall_rd", 32'(stall_rd), 32'd0);
    check("stall_capture", 32'(stall_rsp), 32'd1);
    repeat (6) cycle(1'b0, 1'b0, 32'h0);

    // redirect with a request pending
    flush_cnt = 0;
    cycle(1'b0, 1'b1, 32'h0000_2002);
    cycle(1'b0, 1'b0, 32'h0);
    check("bra_n1_rd",    {31'b0, obs_rd}, 32'd1);
    check("bra_n1_addr",  obs_addr, 32'h0000_2000);
    check("bra_n1_state", {30'b0, obs_state}, {30'b0, ST_FLUSH});
    cycle(1'b0, 1'b0, 32'h0);
    check("bra_n2_state", {30'b0, obs_state}, {30'b0, ST_RUN});
    cycle(1'b0, 1'b0, 32'h0);
    check("bra_n3_valid", {31'b0, obs_valid}, 32'd1);
    check("bra_n3_pc",    obs_pc, 32'h0000_2000);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    check("flush_cycles", 32'(flush_cnt), 32'd1);

    // redirect while stalled with a full skid
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_3000);
    cycle(1'b0, 1'b0, 32'h0);
    check("skbra_n1_valid", {31'b0, obs_valid}, 32'd0);
    check("skbra_n1_rd",    {31'b0, obs_rd}, 32'd1);
    check("skbra_n1_addr",  obs_addr, 32'h0000_3000);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("skbra_n3_pc", obs_pc, 32'h0000_3000);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);

    // address wrap
    saw_wrap = 1'b0;
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (8) cycle(1'b0, 1'b0, 32'h0);
    check("wrap", {31'b0, saw_wrap}, 32'd1);

    // randomized stalls and redirects
    for (int i = 0; i < 2000; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      br  = ($urandom_range(0, 99) < 4);
      tgt = 32'h0000_4000 + $urandom_range(0, 4095);
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      cycle(st, br, tgt);
    end
    repeat (4) cycle(1'b0, 1'b0, 32'h0);

    // one-cycle reset pulse mid-stream
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    pulse_reset();
    boot_sequence("reboot");
    repeat (4) cycle(1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
